// File: rtl/reg_bank_clr.sv
// Parametrised dual-read register bank with write bypass, per-entry pending bits
// and a clear sequencer that zeroes the whole array after reset or on request.
module reg_bank_clr #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              pend_a,
    output logic              pend_b,
    input  logic              clr_req,
    output logic              busy
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic wr_act;
    logic rsv_act;

    function automatic logic is_zero_addr(input logic [ADDR_W-1:0] addr);
        return ZERO_REG && (addr == '0);
    endfunction

    // busy comes straight from the state flop, so it is registered by construction.
    assign busy    = (state_q == CLEAR);
    assign wr_act  = wr_en  && !busy && !is_zero_addr(wr_addr);
    assign rsv_act = rsv_en && !busy && !is_zero_addr(rsv_addr);

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // A reserve issued alongside a write to the same entry wins, so it is applied last.
    always_comb begin
        pend_d = pend_q;
        if (busy) begin
            pend_d[clr_cnt_q] = 1'b0;
        end else begin
            if (wr_act) begin
                pend_d[wr_addr] = 1'b0;
            end
            if (rsv_act) begin
                pend_d[rsv_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // NOTE: the array has no reset; the clear sequencer zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_act) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              pend;

        assign addr = (p == 0) ? rd_addr_a : rd_addr_b;

        // Pending bits are never forwarded; only data takes the bypass path.
        always_comb begin
            data = '0;
            pend = 1'b0;
            if (!busy && !is_zero_addr(addr)) begin
                pend = pend_q[addr];
                if (BYPASS && wr_act && (wr_addr == addr)) begin
                    data = wr_data;
                end else begin
                    data = mem_q[addr];
                end
            end
        end
    end

    assign rd_data_a = g_rd[0].data;
    assign rd_data_b = g_rd[1].data;
    assign pend_a    = g_rd[0].pend;
    assign pend_b    = g_rd[1].pend;

endmodule

// File: tb/tb_reg_bank_clr.sv
// Randomised and directed bench for reg_bank_clr: two instances (bypass / zero-register
// variants) driven in parallel and compared against an array-based reference model.
module tb_reg_bank_clr;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en, rsv_en, clr_req;
    logic [ADDR_W-1:0] wr_addr, rsv_addr, rd_addr_a, rd_addr_b;
    logic [DATA_W-1:0] wr_data;

    logic [DATA_W-1:0] rda0, rdb0, rda1, rdb1;
    logic              pa0, pb0, pa1, pb1, busy0, busy1;

    // Instance 0: ZERO_REG = 0, BYPASS = 1.  Instance 1: ZERO_REG = 1, BYPASS = 0.
    reg_bank_clr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rda0), .rd_addr_b(rd_addr_b), .rd_data_b(rdb0),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_a(pa0), .pend_b(pb0),
        .clr_req(clr_req), .busy(busy0)
    );

    reg_bank_clr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_zb (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rda1), .rd_addr_b(rd_addr_b), .rd_data_b(rdb1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_a(pa1), .pend_b(pb1),
        .clr_req(clr_req), .busy(busy1)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem_m  [2][DEPTH];
    bit                pend_m [2][DEPTH];
    int                clr_left;
    int                n_checks;
    int                n_fail;

    function automatic bit zr(input int i);
        return i == 1;
    endfunction

    function automatic bit byp(input int i);
        return i == 0;
    endfunction

    function automatic logic [DATA_W-1:0] exp_data(input int i, input logic [ADDR_W-1:0] a);
        if (clr_left > 0) return '0;
        if (zr(i) && a == 0) return '0;
        if (byp(i) && wr_en && wr_addr == a && !(zr(i) && wr_addr == 0)) return wr_data;
        return mem_m[i][a];
    endfunction

    function automatic logic exp_pend(input int i, input logic [ADDR_W-1:0] a);
        if (clr_left > 0) return 1'b0;
        if (zr(i) && a == 0) return 1'b0;
        return pend_m[i][a];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("busy0", busy0, clr_left > 0);
        check("busy1", busy1, clr_left > 0);
        check("rd_a0", rda0, exp_data(0, rd_addr_a));
        check("rd_b0", rdb0, exp_data(0, rd_addr_b));
        check("rd_a1", rda1, exp_data(1, rd_addr_a));
        check("rd_b1", rdb1, exp_data(1, rd_addr_b));
        check("pend_a0", pa0, exp_pend(0, rd_addr_a));
        check("pend_b0", pb0, exp_pend(0, rd_addr_b));
        check("pend_a1", pa1, exp_pend(1, rd_addr_a));
        check("pend_b1", pb1, exp_pend(1, rd_addr_b));
    endtask

    task automatic model_edge();
        if (!rst_n) return;
        if (clr_left > 0) begin
            for (int i = 0; i < 2; i++) begin
                mem_m[i][DEPTH - clr_left]  = '0;
                pend_m[i][DEPTH - clr_left] = 1'b0;
            end
            clr_left--;
        end else begin
            if (clr_req) clr_left = DEPTH;
            for (int i = 0; i < 2; i++) begin
                if (wr_en && !(zr(i) && wr_addr == 0)) begin
                    mem_m[i][wr_addr]  = wr_data;
                    pend_m[i][wr_addr] = 1'b0;
                end
                if (rsv_en && !(zr(i) && rsv_addr == 0)) pend_m[i][rsv_addr] = 1'b1;
            end
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_idle();
        wr_en   = 1'b0;
        rsv_en  = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic assert_reset();
        rst_n    = 1'b0;
        clr_left = DEPTH;
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < DEPTH; a++) pend_m[i][a] = 1'b0;
    endtask

    task automatic count_busy(input string tag);
        int n;
        n = 0;
        while (busy0 === 1'b1 && n < 100) begin
            wr_en    = 1'b1;
            wr_addr  = ADDR_W'($urandom);
            wr_data  = DATA_W'($urandom) | 16'h0001;
            rsv_en   = 1'($urandom);
            rsv_addr = ADDR_W'($urandom);
            clr_req  = (n == 5);
            cycle();
            n++;
        end
        set_idle();
        check(tag, n, DEPTH);
    endtask

    task automatic read_all_zero();
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr_a = ADDR_W'(a);
            rd_addr_b = ADDR_W'(DEPTH - 1 - a);
            #1;
            check("clr_zero_a", rda0, 0);
            check("clr_zero_b", rdb1, 0);
            check("clr_pend", pa0, 0);
            cycle();
        end
    endtask

    task automatic fill_all();
        for (int a = 0; a < DEPTH; a++) begin
            wr_en   = 1'b1;
            wr_addr = ADDR_W'(a);
            wr_data = DATA_W'((a + 1) * 16'h0101);
            rsv_en  = 1'b0;
            cycle();
        end
        set_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clr_left = DEPTH;
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < DEPTH; a++) begin
                mem_m[i][a]  = '0;
                pend_m[i][a] = 1'b0;
            end
        rst_n = 1'b1;
        set_idle();
        wr_addr = '0; wr_data = '0; rsv_addr = '0; rd_addr_a = '0; rd_addr_b = '0;

        // Reset release: busy for DEPTH edges, then every entry reads zero.
        @(negedge clk);
        assert_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
        count_busy("rst_busy_len");
        read_all_zero();

        // Write then read, same cycle (bypass vs no bypass) and next cycle.
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF; rd_addr_a = 4'd5;
        #1;
        check("bypass_on", rda0, 16'hBEEF);
        check("bypass_off", rda1, 16'h0000);
        cycle();
        set_idle();
        #1;
        check("wr_next0", rda0, 16'hBEEF);
        check("wr_next1", rda1, 16'hBEEF);
        cycle();

        // Reserve, clear by write, then write and reserve together.
        rsv_en = 1'b1; rsv_addr = 4'd3; rd_addr_b = 4'd3;
        cycle();
        set_idle();
        #1;
        check("rsv_pend", pb0, 1);
        cycle();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234;
        cycle();
        set_idle();
        #1;
        check("wr_clr_pend", pb0, 0);
        check("wr_data_r3", rdb0, 16'h1234);
        cycle();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h5678; rsv_en = 1'b1; rsv_addr = 4'd3;
        cycle();
        set_idle();
        #1;
        check("wr_rsv_pend", pb0, 1);
        check("wr_rsv_data", rdb0, 16'h5678);
        cycle();

        // Zero register: writes and reserves to r0 discarded on instance 1 only.
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF; rsv_en = 1'b1; rsv_addr = 4'd0;
        rd_addr_a = 4'd0; rd_addr_b = 4'd0;
        #1;
        check("zr_same_a", rda1, 0);
        check("zr_same_b", rdb1, 0);
        check("zr_same_p", pa1, 0);
        check("nzr_bypass", rda0, 16'hFFFF);
        cycle();
        set_idle();
        #1;
        check("zr_next_a", rda1, 0);
        check("zr_next_pb", pb1, 0);
        check("nzr_next", rdb0, 16'hFFFF);
        check("nzr_pend", pa0, 1);
        cycle();

        // Random traffic, including occasional clear requests.
        for (int k = 0; k < 400; k++) begin
            wr_en     = ($urandom_range(0, 2) != 0);
            wr_addr   = ADDR_W'($urandom);
            wr_data   = DATA_W'($urandom);
            rsv_en    = ($urandom_range(0, 3) == 0);
            rsv_addr  = ADDR_W'($urandom);
            rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom);
            rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : ADDR_W'($urandom);
            clr_req   = ($urandom_range(0, 49) == 0);
            cycle();
        end
        set_idle();
        for (int k = 0; k < DEPTH + 2; k++) cycle();

        // Requested clear with writes attempted mid-sequence.
        fill_all();
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        count_busy("clr_busy_len");
        read_all_zero();

        // Reset asserted when the clear counter reaches 7.
        fill_all();
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        repeat (7) cycle();
        assert_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
        count_busy("rst_mid_len");
        read_all_zero();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
